vx_cache_data_wb: RTL and testbench

VX_CACHE_DATA_WB -- requirements
Module: VX_cache_data_wb

---
 rtl/vx_cache_data_wb_pkg.sv | 35 +++
 rtl/vx_cache_data_wb_dirty.sv | 38 +++
 rtl/vx_cache_data_wb.sv | 217 +++++++++++++++++++++
 tb/tb_vx_cache_data_wb.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vx_cache_data_wb_pkg.sv
// Shared definitions for the cache data/writeback block: derived geometry
// helpers, FSM state encoding and the way one-hot encoder.
package vx_cache_data_wb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calc_wpl(input int line_size, input int word_size);
    return line_size / word_size;
  endfunction

  function automatic int calc_lines(input int cache_size, input int line_size,
                                    input int num_banks, input int num_ways);
    return cache_size / (line_size * num_banks * num_ways);
  endfunction

  // OR-based one-hot to index encoder (up to 16 ways)
  function automatic logic [3:0] oh_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    logic [3:0] k;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      k = 4'(i);
      if (oh[k]) idx = idx | k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/vx_cache_data_wb_dirty.sv
// Per-byte dirty masks, one array per way: sync write, async read, and a
// sweep port that clears one line across all ways per cycle.
module vx_cache_data_wb_dirty #(
  parameter int LINES     = 64,
  parameter int NUM_WAYS  = 1,
  parameter int LINE_SIZE = 16,
  parameter int LSEL_W    = 6,
  parameter int WAY_W     = 1
) (
  input  logic                 clk_i,
  input  logic                 sweep_i,
  input  logic [LSEL_W-1:0]    sweep_line_i,
  input  logic                 we_i,
  input  logic [LSEL_W-1:0]    line_i,
  input  logic [WAY_W-1:0]     way_i,
  input  logic [LINE_SIZE-1:0] wdata_i,
  output logic [LINE_SIZE-1:0] rdata_o
);

  logic [NUM_WAYS-1:0][LINE_SIZE-1:0] rd_way;

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    logic [LINE_SIZE-1:0] mask_q [LINES];

    // Sweep clear wins; it only runs while no ops are being accepted
    always_ff @(posedge clk_i) begin
      if (sweep_i)
        mask_q[sweep_line_i] <= '0;
      else if (we_i && (way_i == WAY_W'(g)))
        mask_q[line_i] <= wdata_i;
    end

    assign rd_way[g] = mask_q[line_i];
  end

  assign rdata_o = rd_way[way_i];

endmodule

// File: rtl/vx_cache_data_wb.sv
// Cache data array with dirty tracking. Writes/fills are staged one cycle in
// a bypass register before retiring to the array, so reads/evicts of the
// same line-way merge the staged bytes.
module vx_cache_data_wb
  import vx_cache_data_wb_pkg::*;
#(
  parameter int CACHE_SIZE = 1024,
  parameter int LINE_SIZE  = 16,
  parameter int NUM_BANKS  = 1,
  parameter int NUM_WAYS   = 1,
  parameter int WORD_SIZE  = 4,
  parameter int WRITEBACK  = 1,
  localparam int WPL    = calc_wpl(LINE_SIZE, WORD_SIZE),
  localparam int LINES  = calc_lines(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS),
  localparam int LSEL_W = log2up(LINES),
  localparam int WSEL_W = log2up(WPL)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   stall_i,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic                   fill_i,
  input  logic                   evict_i,
  input  logic [LSEL_W-1:0]      line_sel_i,
  input  logic [WSEL_W-1:0]      wsel_i,
  input  logic [NUM_WAYS-1:0]    way_sel_i,
  input  logic [WORD_SIZE-1:0]   byteen_i,
  input  logic [WORD_SIZE*8-1:0] write_data_i,
  input  logic [LINE_SIZE*8-1:0] fill_data_i,
  output logic                   init_done_o,
  output logic                   rsp_valid_o,
  output logic [WORD_SIZE*8-1:0] read_data_o,
  output logic [LINE_SIZE*8-1:0] evict_data_o,
  output logic [LINE_SIZE-1:0]   evict_dirty_o
);

  localparam int WAY_W = log2up(NUM_WAYS);
  localparam int LW    = LINE_SIZE * 8;
  localparam int WW    = WORD_SIZE * 8;
  // Write-through direct-mapped caches never write words, only fill lines
  localparam bit WR_USED = !((WRITEBACK == 0) && (NUM_WAYS == 1));

  state_e            state_q, state_d;
  logic [LSEL_W-1:0] cnt_q, cnt_d;
  logic              sweep;

  logic [WAY_W-1:0] way_idx;
  logic             run, acc_rd, acc_wr, acc_fill, acc_ev;

  assign way_idx  = WAY_W'(oh_to_idx(16'(way_sel_i)));
  assign run      = (state_q == ST_RUN) && !stall_i;
  assign acc_rd   = run && read_i;
  assign acc_wr   = run && write_i && WR_USED;
  assign acc_fill = run && fill_i;
  assign acc_ev   = run && evict_i;

  // FSM state and sweep counter
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // INIT clears one line of dirty state per cycle, then hands over to RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sweep   = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LSEL_W'(LINES - 1)) state_d = ST_RUN;
      end
      default: ;
    endcase
  end

  assign init_done_o = (state_q == ST_RUN);

  // ---- staged write (bypass) register ----
  logic                 byp_vld_q;
  logic [LSEL_W-1:0]    byp_line_q;
  logic [WAY_W-1:0]     byp_way_q;
  logic [LW-1:0]        byp_data_q;
  logic [LINE_SIZE-1:0] byp_mask_q;
  logic [LW-1:0]        byp_bmask;
  logic [WPL-1:0][WORD_SIZE-1:0] wr_mask;

  // Byte enables of the word write placed at word wsel within the line
  always_comb begin
    wr_mask         = '0;
    wr_mask[wsel_i] = byteen_i;
  end

  for (genvar g = 0; g < LINE_SIZE; g++) begin : g_bm
    assign byp_bmask[g*8 +: 8] = {8{byp_mask_q[g]}};
  end

  // Valid bit: a reset drops whatever is staged
  always_ff @(posedge clk_i) begin
    if (!reset_i)      byp_vld_q <= 1'b0;
    else if (!stall_i) byp_vld_q <= acc_wr || acc_fill;
  end

  // Capture the accepted write/fill as a line-wide byte-masked update
  always_ff @(posedge clk_i) begin
    if (acc_wr || acc_fill) begin
      byp_line_q <= line_sel_i;
      byp_way_q  <= way_idx;
      byp_data_q <= acc_fill ? fill_data_i : {WPL{write_data_i}};
      byp_mask_q <= acc_fill ? '1 : wr_mask;
    end
  end

  // ---- data array ----
  logic [LW-1:0] mem_q [LINES][NUM_WAYS];
  logic          commit;
  logic [LW-1:0] ram_line;
  logic [LW-1:0] line_m;
  logic [WPL-1:0][WW-1:0] line_words;

  assign commit = reset_i && !stall_i && byp_vld_q;

  // Retire the staged bytes into the array one cycle after acceptance
  always_ff @(posedge clk_i) begin
    if (commit)
      mem_q[byp_line_q][byp_way_q] <= (mem_q[byp_line_q][byp_way_q] & ~byp_bmask) |
                                      (byp_data_q & byp_bmask);
  end

  assign ram_line = mem_q[line_sel_i][way_idx];

  // Merge the not-yet-retired bytes over the array copy on a line-way hit
  always_comb begin
    line_m = ram_line;
    if (byp_vld_q && (byp_line_q == line_sel_i) && (byp_way_q == way_idx))
      line_m = (ram_line & ~byp_bmask) | (byp_data_q & byp_bmask);
  end

  assign line_words = line_m;

  // ---- dirty masks ----
  logic [LINE_SIZE-1:0] dirty_rd, dirty_wd;
  logic                 dirty_we;

  // Writes accumulate bytes; fills and evicts leave the line clean
  always_comb begin
    dirty_wd = '0;
    if (acc_wr) dirty_wd = dirty_rd | wr_mask;
  end

  assign dirty_we = reset_i && (acc_wr || acc_fill || acc_ev);

  if (WRITEBACK != 0) begin : g_dirty
    vx_cache_data_wb_dirty #(
      .LINES     (LINES),
      .NUM_WAYS  (NUM_WAYS),
      .LINE_SIZE (LINE_SIZE),
      .LSEL_W    (LSEL_W),
      .WAY_W     (WAY_W)
    ) u_dirty (
      .clk_i        (clk_i),
      .sweep_i      (sweep),
      .sweep_line_i (cnt_q),
      .we_i         (dirty_we),
      .line_i       (line_sel_i),
      .way_i        (way_idx),
      .wdata_i      (dirty_wd),
      .rdata_o      (dirty_rd)
    );
  end else begin : g_nodirty
    assign dirty_rd = '0;
  end

  // ---- response registers (held while stalled) ----
  logic                 rsp_valid_q;
  logic [WW-1:0]        read_data_q;
  logic [LW-1:0]        evict_data_q;
  logic [LINE_SIZE-1:0] evict_dirty_q;

  // One-cycle read/evict response; contents hold until the next such op
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rsp_valid_q   <= 1'b0;
      read_data_q   <= '0;
      evict_data_q  <= '0;
      evict_dirty_q <= '0;
    end else if (!stall_i) begin
      rsp_valid_q <= acc_rd || acc_ev;
      if (acc_rd) read_data_q <= line_words[wsel_i];
      if (acc_ev) begin
        evict_data_q  <= line_m;
        evict_dirty_q <= dirty_rd;
      end
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign read_data_o   = read_data_q;
  assign evict_data_o  = evict_data_q;
  assign evict_dirty_o = evict_dirty_q;

  // Protocol checks: one strobe at a time, one-hot way with any strobe
  logic [3:0] ops;
  assign ops = {read_i, write_i, fill_i, evict_i};

  a_one_op: assert property (@(posedge clk_i) disable iff (!reset_i) $onehot0(ops));
  a_oh_way: assert property (@(posedge clk_i) disable iff (!reset_i)
                             (|ops) |-> $onehot(way_sel_i));

endmodule

// File: tb/tb_vx_cache_data_wb.sv
// Randomized bench for vx_cache_data_wb against a byte-array reference model.
module tb_vx_cache_data_wb;

  localparam int LS    = 16;
  localparam int NW    = 2;
  localparam int LINES = 16;

  logic         clk = 1'b0;
  logic         rst_n, stall, rd, wr, fl, ev;
  logic [3:0]   lsel;
  logic [1:0]   wsel;
  logic [1:0]   way_sel;
  logic [3:0]   byteen;
  logic [31:0]  wdata;
  logic [127:0] fdata;
  logic         init_done, rsp_valid;
  logic [31:0]  rdata;
  logic [127:0] ev_data;
  logic [15:0]  ev_dirty;

  always #5 clk = ~clk;

  vx_cache_data_wb #(
    .CACHE_SIZE (512),
    .LINE_SIZE  (16),
    .NUM_BANKS  (1),
    .NUM_WAYS   (2),
    .WORD_SIZE  (4),
    .WRITEBACK  (1)
  ) dut (
    .clk_i         (clk),
    .reset_i       (rst_n),
    .stall_i       (stall),
    .read_i        (rd),
    .write_i       (wr),
    .fill_i        (fl),
    .evict_i       (ev),
    .line_sel_i    (lsel),
    .wsel_i        (wsel),
    .way_sel_i     (way_sel),
    .byteen_i      (byteen),
    .write_data_i  (wdata),
    .fill_data_i   (fdata),
    .init_done_o   (init_done),
    .rsp_valid_o   (rsp_valid),
    .read_data_o   (rdata),
    .evict_data_o  (ev_data),
    .evict_dirty_o (ev_dirty)
  );

  // reference model: plain byte storage and per-line dirty bits
  logic [7:0]   mem_m   [LINES][NW][LS];
  logic [15:0]  dirty_m [LINES][NW];
  bit           run_m;
  int           cnt_m;
  logic         exp_rsp;
  logic [31:0]  exp_rd;
  logic [127:0] exp_evd;
  logic [15:0]  exp_evm;
  int           n_chk, n_pass;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] line_of(input int l, input int w);
    logic [127:0] v;
    for (int b = 0; b < LS; b++) v[b*8 +: 8] = mem_m[l][w][b];
    return v;
  endfunction

  // op: 0 idle, 1 read, 2 write, 3 fill, 4 evict
  task automatic drive(input int op, input int l, input int w, input int ws);
    rd = (op == 1); wr = (op == 2); fl = (op == 3); ev = (op == 4);
    lsel = 4'(l); way_sel = 2'(1 << w); wsel = 2'(ws);
  endtask

  // apply the current inputs to the model, clock once, compare all outputs
  task automatic tick();
    int l, w, ws;
    l = int'(lsel); w = way_sel[1] ? 1 : 0; ws = int'(wsel);
    if (!rst_n) begin
      run_m = 0; cnt_m = 0;
      exp_rsp = 0; exp_rd = '0; exp_evd = '0; exp_evm = '0;
    end else if (!run_m) begin
      if (!stall) exp_rsp = 0;
      cnt_m++;
      if (cnt_m == LINES) begin
        run_m = 1;
        for (int i = 0; i < LINES; i++)
          for (int j = 0; j < NW; j++) dirty_m[i][j] = '0;
      end
    end else if (!stall) begin
      exp_rsp = rd || ev;
      if (rd)
        for (int k = 0; k < 4; k++) exp_rd[k*8 +: 8] = mem_m[l][w][ws*4+k];
      if (ev) begin
        exp_evd = line_of(l, w);
        exp_evm = dirty_m[l][w];
        dirty_m[l][w] = '0;
      end
      if (wr)
        for (int k = 0; k < 4; k++)
          if (byteen[k]) begin
            mem_m[l][w][ws*4+k] = wdata[k*8 +: 8];
            dirty_m[l][w][ws*4+k] = 1'b1;
          end
      if (fl) begin
        for (int b = 0; b < LS; b++) mem_m[l][w][b] = fdata[b*8 +: 8];
        dirty_m[l][w] = '0;
      end
    end
    @(posedge clk); #1;
    chk("init_done",   init_done, run_m);
    chk("rsp_valid",   rsp_valid, exp_rsp);
    chk("read_data",   rdata,     exp_rd);
    chk("evict_data",  ev_data,   exp_evd);
    chk("evict_dirty", ev_dirty,  exp_evm);
  endtask

  initial begin
    int n;
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; stall = 1'b0; byteen = '0; wdata = '0; fdata = '0;
    drive(0, 0, 0, 0);
    run_m = 0; cnt_m = 0; exp_rsp = 0; exp_rd = '0; exp_evd = '0; exp_evm = '0;
    tick(); tick();

    // release reset with a read pending during the sweep
    rst_n = 1'b1; drive(1, 0, 0, 0);
    for (n = 1; n <= 40; n++) begin
      tick();
      if (init_done) break;
    end
    drive(0, 0, 0, 0);
    chk("init_lat", n, 16);

    // fill every line-way; line 3 way 1 last, with bytes 0x00..0x0F
    for (int l = 0; l < LINES; l++)
      for (int w = 0; w < NW; w++)
        if (!(l == 3 && w == 1)) begin
          fdata = {$urandom, $urandom, $urandom, $urandom};
          drive(3, l, w, 0); tick();
        end
    for (int b = 0; b < LS; b++) fdata[b*8 +: 8] = 8'(b);
    drive(3, 3, 1, 0); tick();
    drive(1, 3, 1, 2); tick();
    chk("fill_rd_vld", rsp_valid, 1);
    chk("fill_rd_data", rdata, 32'h0B0A0908);

    wdata = 32'hDEADBEEF; byteen = 4'b0011;
    drive(2, 3, 1, 0); tick();
    drive(4, 3, 1, 0); tick();
    chk("wr_ev_word0", ev_data[31:0], 32'h0302BEEF);
    chk("wr_ev_dirty", ev_dirty, 16'h0003);
    drive(4, 3, 1, 0); tick();
    chk("ev2_dirty", ev_dirty, 16'h0000);
    drive(3, 3, 1, 0); tick();
    drive(4, 3, 1, 0); tick();
    chk("fill_ev_dirty", ev_dirty, 16'h0000);
    chk("fill_ev_data", ev_data, fdata);

    // read held off by stall for three cycles
    stall = 1'b1; drive(1, 3, 1, 1);
    repeat (3) begin
      tick();
      chk("stall_vld", rsp_valid, 1);
      chk("stall_data", rdata, 32'h0B0A0908);
    end
    stall = 1'b0; tick();
    chk("unstall_data", rdata, 32'h07060504);

    // random traffic on a few lines to hit the bypass often
    for (int i = 0; i < 400; i++) begin
      stall  = ($urandom_range(0, 7) == 0);
      byteen = 4'($urandom);
      wdata  = $urandom;
      fdata  = {$urandom, $urandom, $urandom, $urandom};
      drive($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3));
      tick();
    end

    // reset during a read
    stall = 1'b0; drive(0, 0, 0, 0); tick();
    drive(1, 3, 1, 0); tick();
    rst_n = 1'b0; tick();
    chk("rst_mid_rd", rsp_valid, 0);

    // reset during the sweep, then the sweep restarts from zero
    rst_n = 1'b1; drive(0, 0, 0, 0);
    repeat (5) tick();
    rst_n = 1'b0; tick();
    chk("rst_mid_init", init_done, 0);
    rst_n = 1'b1;
    for (n = 1; n <= 40; n++) begin
      tick();
      if (init_done) break;
    end
    chk("reinit_lat", n, 16);
    drive(1, 3, 1, 1); tick();
    drive(4, 3, 1, 0); tick();
    drive(0, 0, 0, 0); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
